// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, glitch/break handling and a small
// first-word-fall-through receive FIFO read through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state, state_next;
  logic            sync1, rxd_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic            cnt_clear, bit_take, push, stop_bad;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, pop, wr_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= RXD;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    bit_take   = 1'b0;
    push       = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_next = START;
          cnt_clear  = 1'b1;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_clear  = 1'b1;
          state_next = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clear = 1'b1;
          bit_take  = 1'b1;
          if (idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clear = 1'b1;
          if (rxd_s) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (cnt_clear)
        cnt <= '0;
      else if (state == START || state == DATA || state == STOP)
        cnt <= cnt + 1'b1;
      if (state == START)
        idx <= '0;
      else if (bit_take)
        idx <= idx + 1'b1;
      if (bit_take)
        shift[idx] <= rxd_s;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full  = (count == FULL_CNT);
  assign pop   = RX_VALID & RX_READY;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      FRAME_ERR <= stop_bad;
      OVERRUN   <= push & full & ~pop;
    end
  end

  assign RX_DATA  = mem[rd_ptr];
  assign RX_VALID = (count != '0);
  assign BUSY     = (state != IDLE);

endmodule
